// File: rtl/gift_pipe_dec.sv
// Iterative GIFT-128 decryption core: one-time expansion to the round-40 key,
// then one inverse round per clock with the key schedule and constant walked backwards.
module gift_pipe_dec (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inKeyWr,
  input  logic [127:0] inKeyData,
  input  logic         inDataWr,
  input  logic [127:0] inDataData,
  output logic [127:0] outData,
  output logic         outValidData,
  output logic         outReady,
  output logic         outBusy
);

  localparam int unsigned BW         = 128;
  localparam int unsigned CW         = 6;
  localparam int unsigned RW         = 6;
  localparam int unsigned KEY_ROUNDS = 39;
  localparam int unsigned DEC_ROUNDS = 40;
  localparam logic [CW-1:0] LAST_RC  = 6'h1A;

  typedef enum logic [1:0] {NOKEY, KEYEXP, READY, DEC} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] key_q, key_d;
  logic [BW-1:0] last_key_q, last_key_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [CW-1:0] rc_q, rc_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] data_d;
  logic          valid_d, ready_d, busy_d;
  logic [BW-1:0] round_out;
  logic [BW-1:0] key_fwd_next;

  // Forward key update: k7..k0 <- (k1>>>2) | (k0>>>12) | k7..k2
  function automatic logic [BW-1:0] key_fwd(input logic [BW-1:0] k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction

  // Backward key update, exact inverse of key_fwd
  function automatic logic [BW-1:0] key_bwd(input logic [BW-1:0] k);
    return {k[95:0], k[125:112], k[127:126], k[99:96], k[111:100]};
  endfunction

  function automatic logic [CW-1:0] rc_bwd(input logic [CW-1:0] c);
    return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    case (n)
      4'h0: inv_sbox = 4'hd;  4'h1: inv_sbox = 4'h0;
      4'h2: inv_sbox = 4'h8;  4'h3: inv_sbox = 4'h6;
      4'h4: inv_sbox = 4'h2;  4'h5: inv_sbox = 4'hc;
      4'h6: inv_sbox = 4'h4;  4'h7: inv_sbox = 4'hb;
      4'h8: inv_sbox = 4'he;  4'h9: inv_sbox = 4'h7;
      4'ha: inv_sbox = 4'h1;  4'hb: inv_sbox = 4'ha;
      4'hc: inv_sbox = 4'h3;  4'hd: inv_sbox = 4'h9;
      4'he: inv_sbox = 4'hf;  default: inv_sbox = 4'h5;
    endcase
  endfunction

  // AddRoundKey+const, inverse PermBits, inverse S-box
  function automatic logic [BW-1:0] inv_round(input logic [BW-1:0] s,
                                              input logic [BW-1:0] k,
                                              input logic [CW-1:0] c);
    logic [BW-1:0] a;
    logic [BW-1:0] p;
    logic [BW-1:0] r;
    int            src;
    a = s;
    for (int i = 0; i < 32; i++) begin
      a[4*i+2] = a[4*i+2] ^ k[64+i];
      a[4*i+1] = a[4*i+1] ^ k[i];
    end
    for (int j = 0; j < 6; j++) a[4*j+3] = a[4*j+3] ^ c[j];
    a[127] = ~a[127];
    for (int i = 0; i < 128; i++) begin
      src  = 4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
      p[i] = a[src];
    end
    for (int n = 0; n < 32; n++) r[4*n +: 4] = inv_sbox(p[4*n +: 4]);
    return r;
  endfunction

  assign round_out    = inv_round(blk_q, key_q, rc_q);
  assign key_fwd_next = key_fwd(key_q);

  // Next-state and datapath control; a key write preempts everything
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    last_key_d = last_key_q;
    blk_d      = blk_q;
    rc_d       = rc_q;
    cnt_d      = cnt_q;
    data_d     = outData;
    valid_d    = 1'b0;
    if (inKeyWr) begin
      key_d   = inKeyData;
      cnt_d   = '0;
      state_d = KEYEXP;
    end else begin
      case (state_q)
        KEYEXP: begin
          key_d = key_fwd_next;
          if (cnt_q == RW'(KEY_ROUNDS - 1)) begin
            last_key_d = key_fwd_next;
            cnt_d      = '0;
            state_d    = READY;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end
        READY: begin
          if (inDataWr) begin
            blk_d   = inDataData;
            key_d   = last_key_q;
            rc_d    = LAST_RC;
            cnt_d   = '0;
            state_d = DEC;
          end
        end
        DEC: begin
          blk_d = round_out;
          key_d = key_bwd(key_q);
          rc_d  = rc_bwd(rc_q);
          if (cnt_q == RW'(DEC_ROUNDS - 1)) begin
            data_d  = round_out;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = READY;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end
        default: ;
      endcase
    end
    ready_d = (state_d == READY);
    busy_d  = (state_d == KEYEXP) || (state_d == DEC);
  end

  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      state_q      <= NOKEY;
      key_q        <= '0;
      last_key_q   <= '0;
      blk_q        <= '0;
      rc_q         <= '0;
      cnt_q        <= '0;
      outData      <= '0;
      outValidData <= 1'b0;
      outReady     <= 1'b0;
      outBusy      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      last_key_q   <= last_key_d;
      blk_q        <= blk_d;
      rc_q         <= rc_d;
      cnt_q        <= cnt_d;
      outData      <= data_d;
      outValidData <= valid_d;
      outReady     <= ready_d;
      outBusy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_gift_pipe_dec.sv
// Bench for gift_pipe_dec: known vectors, random blocks against a round-key-table
// reference decryptor, plus abort, dropped-write and mid-operation reset cases.
module tb_gift_pipe_dec;

  logic         inClk = 1'b0;
  logic         inRstN;
  logic         inKeyWr;
  logic [127:0] inKeyData;
  logic         inDataWr;
  logic [127:0] inDataData;
  logic [127:0] outData;
  logic         outValidData;
  logic         outReady;
  logic         outBusy;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] last_pt;

  gift_pipe_dec dut (
    .inClk(inClk), .inRstN(inRstN), .inKeyWr(inKeyWr), .inKeyData(inKeyData),
    .inDataWr(inDataWr), .inDataData(inDataData), .outData(outData),
    .outValidData(outValidData), .outReady(outReady), .outBusy(outBusy)
  );

  always #5 inClk = ~inClk;

  localparam logic [3:0] SBOX [16] = '{4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
                                       4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he};

  // Reference: precompute all 40 round keys and constants forwards, then undo rounds 40..1
  function automatic logic [127:0] ref_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [15:0]  k [8];
    logic [63:0]  rk [40];
    logic [5:0]   rc [40];
    logic [3:0]   inv [16];
    logic [5:0]   c;
    logic [15:0]  k0, k1;
    logic [127:0] s, t;
    int           p;
    for (int v = 0; v < 16; v++) inv[SBOX[v]] = 4'(v);
    for (int w = 0; w < 8; w++) k[w] = key[16*w +: 16];
    c = 6'h00;
    for (int r = 0; r < 40; r++) begin
      c     = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      rc[r] = c;
      rk[r] = {k[5], k[4], k[1], k[0]};
      k0 = k[0];
      k1 = k[1];
      for (int w = 0; w < 6; w++) k[w] = k[w+2];
      k[7] = {k1[1:0], k1[15:2]};
      k[6] = {k0[11:0], k0[15:12]};
    end
    s = ct;
    for (int r = 39; r >= 0; r--) begin
      for (int i = 0; i < 32; i++) begin
        s[4*i+2] ^= rk[r][32+i];
        s[4*i+1] ^= rk[r][i];
      end
      for (int j = 0; j < 6; j++) s[4*j+3] ^= rc[r][j];
      s[127] ^= 1'b1;
      for (int i = 0; i < 128; i++) begin
        p    = 4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
        t[i] = s[p];
      end
      for (int n = 0; n < 32; n++) s[4*n +: 4] = inv[t[4*n +: 4]];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  // Waits for ready with a cycle bound; optionally pokes a data write at cycle `poke`
  task automatic wait_ready(input int poke, output int n, output int vcount);
    n      = 0;
    vcount = 0;
    while (!outReady && n < 200) begin
      if (n == poke) begin
        inDataWr   = 1'b1;
        inDataData = rand128();
      end
      tick();
      inDataWr = 1'b0;
      n++;
      if (outValidData) vcount++;
    end
  endtask

  task automatic load_key(input logic [127:0] k, input bit with_data, input int poke);
    int n, v;
    inKeyWr    = 1'b1;
    inKeyData  = k;
    inDataWr   = with_data;
    inDataData = rand128();
    tick();
    inKeyWr  = 1'b0;
    inDataWr = 1'b0;
    check("key_busy", 128'(outBusy), 128'(1));
    check("key_ready", 128'(outReady), 128'(0));
    check("key_valid0", 128'(outValidData), 128'(0));
    wait_ready(poke, n, v);
    check("key_lat", 128'(n), 128'(39));
    check("key_novalid", 128'(v), 128'(0));
    check("key_busy_end", 128'(outBusy), 128'(0));
    check("key_data_held", outData, last_pt);
  endtask

  task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp, input int poke);
    int n;
    inDataWr   = 1'b1;
    inDataData = ct;
    tick();
    inDataWr = 1'b0;
    check("dec_busy", 128'(outBusy), 128'(1));
    check("dec_ready", 128'(outReady), 128'(0));
    check("dec_valid0", 128'(outValidData), 128'(0));
    n = 0;
    while (!outValidData && n < 200) begin
      if (n == poke) begin
        inDataWr   = 1'b1;
        inDataData = rand128();
      end
      tick();
      inDataWr = 1'b0;
      n++;
    end
    check("dec_lat", 128'(n), 128'(40));
    check("dec_out", outData, exp);
    check("dec_ready_end", 128'(outReady), 128'(1));
    check("dec_busy_end", 128'(outBusy), 128'(0));
    last_pt = exp;
  endtask

  initial begin
    logic [127:0] k, k2, ct;
    int           cnt;
    inRstN = 1'b0; inKeyWr = 1'b0; inDataWr = 1'b0;
    inKeyData = '0; inDataData = '0; last_pt = '0;
    tick(); tick();
    check("rst_data", outData, 128'(0));
    check("rst_flags", {125'(0), outValidData, outReady, outBusy}, 128'(0));
    inRstN = 1'b1;

    // Data write with no key loaded
    inDataWr = 1'b1; inDataData = rand128(); tick(); inDataWr = 1'b0; tick();
    check("nokey_flags", {125'(0), outValidData, outReady, outBusy}, 128'(0));

    load_key(128'h0, 1'b0, -1);
    decrypt(128'hcd0bd738388ad3f668b15a36ceb6ff92, 128'h0, -1);

    load_key(128'hfedcba9876543210fedcba9876543210, 1'b0, -1);
    decrypt(128'h8422241a6dbf5a9346af468409ee0152, 128'hfedcba9876543210fedcba9876543210, -1);

    // Back-to-back with key reuse
    k = 128'hd0f5c59a7700d3e799028fa9f90ad837;
    load_key(k, 1'b0, -1);
    decrypt(128'h13ede67cbdcc3dbf400a62d6977265ea, 128'he39c141fa57dba43f08a85b6a91f86c1, -1);
    decrypt(128'hcd0bd738388ad3f668b15a36ceb6ff92,
            ref_dec(k, 128'hcd0bd738388ad3f668b15a36ceb6ff92), -1);

    // Data writes during KEYEXP and mid-DEC are ignored
    k = rand128();
    load_key(k, 1'b0, 10);
    ct = rand128();
    decrypt(ct, ref_dec(k, ct), 15);

    // Key write at round 20 aborts the block
    k2 = rand128();
    ct = rand128();
    inDataWr = 1'b1; inDataData = ct; tick(); inDataWr = 1'b0;
    repeat (19) tick();
    load_key(k2, 1'b0, -1);
    ct = rand128();
    decrypt(ct, ref_dec(k2, ct), -1);

    // Simultaneous key and data: key wins
    k = rand128();
    load_key(k, 1'b1, -1);
    decrypt(ct, ref_dec(k, ct), -1);

    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin
        k = rand128();
        load_key(k, 1'b0, -1);
      end
      ct = rand128();
      decrypt(ct, ref_dec(k, ct), -1);
    end

    // One-cycle reset mid-decryption, then a data write that must be ignored
    ct = rand128();
    inDataWr = 1'b1; inDataData = ct; tick(); inDataWr = 1'b0;
    repeat (15) tick();
    inRstN = 1'b0; tick(); inRstN = 1'b1;
    check("mrst_data", outData, 128'(0));
    check("mrst_flags", {125'(0), outValidData, outReady, outBusy}, 128'(0));
    last_pt = '0;
    inDataWr = 1'b1; inDataData = ct; tick(); inDataWr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (outValidData || outReady || outBusy) cnt++;
      tick();
    end
    check("mrst_ignored", 128'(cnt), 128'(0));
    check("mrst_data_held", outData, 128'(0));
    load_key(k, 1'b0, -1);
    decrypt(ct, ref_dec(k, ct), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gift_pipe_dec.md
# gift_pipe_dec

Iterative GIFT-128 decryption core, the decrypt-side counterpart of the pipelined encryptor. It accepts a 128-bit master key and expands it once to the round-40 key. It then decrypts one 128-bit ciphertext block at a time, applying one inverse round per clock and walking the key schedule and round constant backwards. Its external handshake matches the encryptor's write/valid interface so both cores can sit behind the same host wrapper.

## Interface
- No parameters. Round count is fixed at 40 and key/block width at 128.
- `inClk` in 1: sole clock, rising edge.
- `inRstN` in 1: synchronous, active-low reset.
- `inKeyWr` in 1: one-cycle strobe; loads `inKeyData`.
- `inKeyData` in 128: master key; bit 127 is the MSB of k7.
- `inDataWr` in 1: one-cycle strobe; loads `inDataData` as ciphertext.
- `inDataData` in 128: ciphertext; bit 127 is the MSB.
- `outData` in 128 (output): plaintext; held until the next result or reset.
- `outValidData` out 1: one-cycle pulse marking a new `outData`.
- `outReady` out 1: high when `inDataWr` will be accepted.
- `outBusy` out 1: high during key expansion or decryption.

## Operation
- FSM states: NOKEY, KEYEXP, READY, DEC.
- Reset sets NOKEY, clears all registers, and drives `outData`=0, `outValidData`=0, `outReady`=0, `outBusy`=0.
- **Key expansion**
  - `inKeyWr` in any state loads the working key register, clears the round counter and enters KEYEXP.
  - KEYEXP applies the forward key update for 39 cycles: k7..k0 ← (k1>>>2)‖(k0>>>12)‖k7‖…‖k2, each word 16 bits.
  - After the 39th update, the working key is copied to `lastKey` and the FSM enters READY.
- **Decryption start**
  - `inDataWr` in READY loads the state register from `inDataData`.
  - It also loads the working key from `lastKey`, sets constant c=0x1A and round counter=0, and enters DEC.
- **Inverse round** (one per DEC cycle), in this order:
  1. AddRoundKey+const (an involution): U=k5‖k4 XORs state bits 4i+2; V=k1‖k0 XORs bits 4i+1, for i=0..31. Bit 127 ^= 1; bits 23,19,15,11,7,3 ^= c5..c0.
  2. Inverse PermBits: state bit P(i) moves to bit i, where P(i)=4⌊i/16⌋+32((3⌊(i mod 16)/4⌋+(i mod 4)) mod 4)+(i mod 4).
  3. Inverse S-box on each nibble, table indexed 0..f = d,0,8,6,2,c,4,b,e,7,1,a,3,9,f,5.
- **Per-round backward update**, same cycle as the inverse round:
  - Key: new k7..k2 = old k5..k0; new k1 = old k7<<<2; new k0 = old k6<<<12.
  - Constant: new c4..c0 = old c5..c1; new c5 = old c0^old c5^1.
- **Completion**: after the 40th inverse round, the state is written to `outData`, `outValidData` pulses, and the FSM returns to READY.
- **Boundary and conflict rules**
  - `inDataWr` in NOKEY, KEYEXP or DEC is ignored.
  - `inKeyWr` during DEC aborts the block: no `outValidData`, `outData` unchanged.
  - `inKeyWr` during KEYEXP restarts expansion from the new key.
  - `inKeyWr` and `inDataWr` asserted together: the key wins and the data is dropped.
  - Reset low in any state overrides everything on that edge.

## Timing
- Key written on edge E0:
  - `outBusy`=1 and `outReady`=0 from E0.
  - Updates occur on E1..E39.
  - `outReady`=1 and `outBusy`=0 after E39.
- Data written on edge D0:
  - Inverse rounds occur on D1..D40.
  - `outData` and `outValidData`=1 are registered on D40; the pulse is low again after D41.
  - `outReady` returns to 1 after D40, so a new `inDataWr` in the cycle after D40 is accepted (one block per 41 cycles).
- `outReady` = (state==READY); `outBusy` = (state==KEYEXP or state==DEC). Both are registered.

## Test plan
- **Zero-key vector**: reset; key=0; wait for ready; data=cd0bd738388ad3f668b15a36ceb6ff92 → `outData`=0 with `outValidData` 40 cycles after the write.
- **Second vector**: key=fedcba9876543210fedcba9876543210; data=8422241a6dbf5a9346af468409ee0152 → fedcba9876543210fedcba9876543210.
- **Back-to-back with key reuse**: key=d0f5c59a7700d3e799028fa9f90ad837; data 13ede67cbdcc3dbf400a62d6977265ea, then the zero-key ciphertext from the first case. The first block gives e39c141fa57dba43f08a85b6a91f86c1. The second write, issued the cycle after the first valid, is accepted without re-expansion; check it against the reference model.
- **Abort**: `inKeyWr` at round 20 of DEC → no valid pulse, `outData` unchanged, `outReady` after 39 cycles, and the next decryption uses the new key.
- **Ignored or dropped writes**:
  - `inDataWr` in NOKEY, KEYEXP or mid-DEC → ignored.
  - `inKeyWr` and `inDataWr` together → the data is dropped and KEYEXP runs.
- **Mid-operation reset**: `inRstN`=0 for one cycle during DEC → all outputs 0 and state NOKEY; a subsequent `inDataWr` is ignored.
